// File: rtl/des_pkg.sv
// DES constants and helpers shared by the decryption core and its f-function.
// Bit order everywhere: index 0 is DES bit 1 (the MSB). Tables hold the standard 1-based DES
// positions. Contents:
//   - IP, FP, E, P, PC1 and PC2 tables
//   - the S-box layer
//   - the subkey rotation schedules for decrypt and encrypt
//   - the FSM state enum
//   - typedefs for the 64/56/48/32/28-bit data widths
package des_pkg;

  typedef logic [0:63] blk64_t;
  typedef logic [0:55] key56_t;
  typedef logic [0:47] half48_t;
  typedef logic [0:31] half32_t;
  typedef logic [0:27] half28_t;

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  localparam int unsigned IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Rotation applied to C/D before round r lives at index r-1. Decrypt round 1 uses the PC1
  // result as-is because the sixteen left shifts of the key schedule sum to a full rotation.
  localparam logic [1:0] ROT_DEC [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [1:0] ROT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each row is one S-box in standard row-major order (index = row*16 + column).
  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic blk64_t ip(input blk64_t x);
    blk64_t y;
    for (int i = 0; i < 64; i++) y[i] = x[IP_TAB[i] - 1];
    return y;
  endfunction

  function automatic blk64_t fp(input blk64_t x);
    blk64_t y;
    for (int i = 0; i < 64; i++) y[i] = x[FP_TAB[i] - 1];
    return y;
  endfunction

  function automatic half48_t e_expand(input half32_t x);
    half48_t y;
    for (int i = 0; i < 48; i++) y[i] = x[E_TAB[i] - 1];
    return y;
  endfunction

  function automatic half32_t p_perm(input half32_t x);
    half32_t y;
    for (int i = 0; i < 32; i++) y[i] = x[P_TAB[i] - 1];
    return y;
  endfunction

  // Parity bits (DES bits 8, 16, ..., 64) are simply never selected.
  function automatic key56_t pc1(input blk64_t x);
    key56_t y;
    for (int i = 0; i < 56; i++) y[i] = x[PC1_TAB[i] - 1];
    return y;
  endfunction

  function automatic half48_t pc2(input key56_t x);
    half48_t y;
    for (int i = 0; i < 48; i++) y[i] = x[PC2_TAB[i] - 1];
    return y;
  endfunction

  // Outer bits of each 6-bit group pick the row, inner four the column.
  function automatic half32_t sbox_layer(input half48_t x);
    half32_t    y;
    logic [5:0] six;
    for (int i = 0; i < 8; i++) begin
      six          = x[6*i +: 6];
      y[4*i +: 4]  = SBOX[i][{six[5], six[0], six[4:1]}];
    end
    return y;
  endfunction

  function automatic half28_t rotl28(input half28_t c, input logic [1:0] n);
    unique case (n)
      2'd1:    return {c[1:27], c[0]};
      2'd2:    return {c[2:27], c[0:1]};
      default: return c;
    endcase
  endfunction

  function automatic half28_t rotr28(input half28_t c, input logic [1:0] n);
    unique case (n)
      2'd1:    return {c[27], c[0:26]};
      2'd2:    return {c[26:27], c[0:25]};
      default: return c;
    endcase
  endfunction

endpackage

// File: rtl/des_decrypt_core_if.sv
// Handshake bundle for des_decrypt_core.
//   in_valid/in_ready   : ciphertext + key input handshake
//   data_in, key_in     : ciphertext and key (bit 0 = DES bit 1)
//   out_valid/out_ready : plaintext output handshake
//   data_out            : plaintext
// slave = core side, master = source/sink side.
interface des_decrypt_core_if;
  import des_pkg::*;

  logic   in_valid;
  logic   in_ready;
  blk64_t data_in;
  blk64_t key_in;
  logic   out_valid;
  logic   out_ready;
  blk64_t data_out;

  modport master (
    output in_valid, data_in, key_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, key_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/des_f_function.sv
// DES round function f(R, K) = P(S(E(R) ^ K)), purely combinational.
//   r_i : 32-bit right half
//   k_i : 48-bit round subkey
//   f_o : 32-bit result
module des_f_function
  import des_pkg::*;
(
  input  half32_t r_i,
  input  half48_t k_i,
  output half32_t f_o
);

  half48_t mixed;

  assign mixed = e_expand(r_i) ^ k_i;
  assign f_o   = p_perm(sbox_layer(mixed));

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: one Feistel round per clock, NUM_ROUNDS rounds per block.
//   clk, n_rst : clock and asynchronous active-low reset
//   encrypt    : only when DES_ENCRYPT_EN is defined; 1 = encrypt, sampled on accept
//   bus        : des_decrypt_core_if.slave (input and output valid/ready handshakes)
// Optional feature macro: DES_ENCRYPT_EN (default build is decrypt-only).
module des_decrypt_core
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input logic clk,
  input logic n_rst,
`ifdef DES_ENCRYPT_EN
  input logic encrypt,
`endif
  des_decrypt_core_if.slave bus
);

  localparam logic [4:0] LastRnd = 5'(NUM_ROUNDS);

  state_e     state_q, state_d;
  half32_t    l_q, l_d, r_q, r_d;
  half28_t    c_q, c_d, d_q, d_d;
  logic [4:0] rnd_q, rnd_d;
  blk64_t     dout_q, dout_d;
  logic       ovalid_q, ovalid_d;

  blk64_t     ip_blk;
  key56_t     pc1_key;
  logic [3:0] rnd_idx;
  half28_t    c_rot, d_rot;
  half48_t    subkey;
  half32_t    f_out;

  assign ip_blk  = ip(bus.data_in);
  assign pc1_key = pc1(bus.key_in);
  assign rnd_idx = 4'(rnd_q - 5'd1);

  // C/D registers hold the pre-rotation value; the rotation for the current round is applied
  // here and written back, so the subkey always comes from the freshly rotated halves.
`ifdef DES_ENCRYPT_EN
  logic enc_q, enc_d;
  assign c_rot = enc_q ? rotl28(c_q, ROT_ENC[rnd_idx]) : rotr28(c_q, ROT_DEC[rnd_idx]);
  assign d_rot = enc_q ? rotl28(d_q, ROT_ENC[rnd_idx]) : rotr28(d_q, ROT_DEC[rnd_idx]);
`else
  assign c_rot = rotr28(c_q, ROT_DEC[rnd_idx]);
  assign d_rot = rotr28(d_q, ROT_DEC[rnd_idx]);
`endif

  assign subkey = pc2({c_rot, d_rot});

  des_f_function u_f (
    .r_i (r_q),
    .k_i (subkey),
    .f_o (f_out)
  );

  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    r_d      = r_q;
    c_d      = c_q;
    d_d      = d_q;
    rnd_d    = rnd_q;
    dout_d   = dout_q;
    ovalid_d = ovalid_q;
`ifdef DES_ENCRYPT_EN
    enc_d    = enc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          l_d     = ip_blk[0:31];
          r_d     = ip_blk[32:63];
          c_d     = pc1_key[0:27];
          d_d     = pc1_key[28:55];
          rnd_d   = 5'd1;
`ifdef DES_ENCRYPT_EN
          enc_d   = encrypt;
`endif
          state_d = StRound;
        end
      end
      StRound: begin
        l_d = r_q;
        r_d = l_q ^ f_out;
        c_d = c_rot;
        d_d = d_rot;
        if (rnd_q == LastRnd) begin
          // Output order {R, L} undoes the swap of the last round.
          dout_d   = fp({r_d, l_d});
          ovalid_d = 1'b1;
          state_d  = StDone;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          ovalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      l_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      rnd_q    <= '0;
      dout_q   <= '0;
      ovalid_q <= 1'b0;
`ifdef DES_ENCRYPT_EN
      enc_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      l_q      <= l_d;
      r_q      <= r_d;
      c_q      <= c_d;
      d_q      <= d_d;
      rnd_q    <= rnd_d;
      dout_q   <= dout_d;
      ovalid_q <= ovalid_d;
`ifdef DES_ENCRYPT_EN
      enc_q    <= enc_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = ovalid_q;
  assign bus.data_out  = dout_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed-vector bench for des_decrypt_core with standard DES known-answer vectors.
module tb_des_decrypt_core;
  import des_pkg::*;

  logic clk;
  logic n_rst;
`ifdef DES_ENCRYPT_EN
  logic encrypt;
`endif
  int n_vec;
  int n_err;

  des_decrypt_core_if bus ();

  des_decrypt_core #(
    .NUM_ROUNDS (16)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
`ifdef DES_ENCRYPT_EN
    .encrypt (encrypt),
`endif
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block for a single cycle; caller guarantees in_ready.
  task automatic send(input logic [63:0] key, input logic [63:0] data);
    bus.key_in   = key;
    bus.data_in  = data;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("in_ready_low_after_accept", bus.in_ready, 0);
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_out(input string tag, input logic [63:0] exp);
    int cyc;
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd16);
    check({tag, "_data"}, bus.data_out, exp);
  endtask

  task automatic drain(input string tag, input logic [63:0] exp);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_ovalid_clr"}, bus.out_valid, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_data_kept"}, bus.data_out, exp);
  endtask

  initial begin
    logic seen;
    n_vec         = 0;
    n_err         = 0;
    n_rst         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_in   = '0;
    bus.key_in    = '0;
`ifdef DES_ENCRYPT_EN
    encrypt       = 1'b0;
`endif
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_data_out", bus.data_out, 64'h0);
    n_rst = 1'b1;
    tick();

    // Known vector 1
    send(64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    wait_out("kv1", 64'h0123456789ABCDEF);
    drain("kv1", 64'h0123456789ABCDEF);
    tick();

    // Known vector 2
    send(64'h0E329232EA6D0D73, 64'h0000000000000000);
    wait_out("kv2", 64'h8787878787878787);
    drain("kv2", 64'h8787878787878787);
    tick();

    // Backpressure with in_valid pulses that must be ignored
    send(64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    wait_out("bp", 64'h0123456789ABCDEF);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.data_in  = 64'hDEADBEEF00000000 | 64'(i);
      tick();
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_data", bus.data_out, 64'h0123456789ABCDEF);
      check("bp_in_ready", bus.in_ready, 0);
    end
    // New block offered during the output handshake must not be taken on that edge
    bus.key_in    = 64'h0E329232EA6D0D73;
    bus.data_in   = 64'h0000000000000000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("hs_out_valid_clr", bus.out_valid, 0);
    check("hs_no_same_cycle_accept", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("hs_next_accept", bus.in_ready, 0);
    wait_out("hs", 64'h8787878787878787);
    drain("hs", 64'h8787878787878787);
    tick();

    // Reset mid-operation
    send(64'h0E329232EA6D0D73, 64'h0000000000000000);
    repeat (8) tick();
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_data_out", bus.data_out, 64'h0);
    tick();
    n_rst = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      seen |= bus.out_valid;
    end
    check("mid_rst_no_output", seen, 0);
    check("mid_rst_idle", bus.in_ready, 1);
    send(64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    wait_out("post_rst", 64'h0123456789ABCDEF);
    drain("post_rst", 64'h0123456789ABCDEF);
    tick();

`ifdef DES_ENCRYPT_EN
    encrypt = 1'b1;
    send(64'h133457799BBCDFF1, 64'h0123456789ABCDEF);
    encrypt = 1'b0;
    wait_out("enc", 64'h85E813540F0AB405);
    drain("enc", 64'h85E813540F0AB405);
    tick();
    send(64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    wait_out("dec_after_enc", 64'h0123456789ABCDEF);
    drain("dec_after_enc", 64'h0123456789ABCDEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
